// File: rtl/code_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// code_bus_arbiter_if
//   Bundles every handshake and memory-bus signal of code_bus_arbiter. Signal
//   names are the arbiter's own: i* are arbiter inputs, o* are arbiter outputs.
//
//   Modports:
//     slave  - the arbiter itself (receives requests, drives the memory bus)
//     master - the environment: core requesters plus the code memory model
//
//   Signals:
//     iIfReq/iIfAddr                     fetch request and byte address
//     oIfGnt/oIfValid/oIfData            fetch grant, data-valid pulse, word
//     iDReq/iDWe/iDBe/iDAddr/iDWData     data-port request fields
//     oDGnt/oDValid/oDRData              data-port grant, valid/ack, read word
//     oMem*                              code memory control/address/data
//     iMemReadData                       code memory read data
//     oBusy                              high while an access is in flight
// -----------------------------------------------------------------------------
interface code_bus_arbiter_if;
  logic        iIfReq;
  logic [31:0] iIfAddr;
  logic        oIfGnt;
  logic        oIfValid;
  logic [31:0] oIfData;

  logic        iDReq;
  logic        iDWe;
  logic [3:0]  iDBe;
  logic [31:0] iDAddr;
  logic [31:0] iDWData;
  logic        oDGnt;
  logic        oDValid;
  logic [31:0] oDRData;

  logic        oMemReadEnable;
  logic        oMemWriteEnable;
  logic [3:0]  oMemByteEnable;
  logic [31:0] oMemAddress;
  logic [31:0] oMemWriteData;
  logic [31:0] iMemReadData;

  logic        oBusy;

  modport slave (
    input  iIfReq, iIfAddr, iDReq, iDWe, iDBe, iDAddr, iDWData, iMemReadData,
    output oIfGnt, oIfValid, oIfData, oDGnt, oDValid, oDRData,
           oMemReadEnable, oMemWriteEnable, oMemByteEnable, oMemAddress,
           oMemWriteData, oBusy
  );

  modport master (
    output iIfReq, iIfAddr, iDReq, iDWe, iDBe, iDAddr, iDWData, iMemReadData,
    input  oIfGnt, oIfValid, oIfData, oDGnt, oDValid, oDRData,
           oMemReadEnable, oMemWriteEnable, oMemByteEnable, oMemAddress,
           oMemWriteData, oBusy
  );
endinterface

// File: rtl/code_bus_arbiter.sv
// -----------------------------------------------------------------------------
// code_bus_arbiter
//   Shares the single code-memory bus between the instruction-fetch port (IF)
//   and a data port (D, used for loader / self-modifying-code traffic). One
//   access at a time: arbitrate in IDLE, hold address/data/byte-enables for
//   MEM_LAT cycles in ACCESS, then pulse the owner's Valid for one cycle.
//   D has fixed priority over IF.
//
//   Ports:
//     iCLK    core clock, rising edge
//     iRST_n  asynchronous active-low reset
//     bus     code_bus_arbiter_if.slave (requests, grants, memory bus)
//
//   Parameters:
//     MEM_LAT     memory read latency in cycles, 1..4
//     STARVE_MAX  consecutive D grants tolerated while IF waits (0..7)
//
//   Optional feature (macro CODE_ARB_STARVE_GUARD_EN):
//     When defined, a saturating counter tracks D grants issued while IF is
//     requesting; once it reaches STARVE_MAX, IF wins the next arbitration.
//     When undefined, D priority is strict and IF may starve.
// -----------------------------------------------------------------------------
module code_bus_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  code_bus_arbiter_if.slave bus
);

  if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_MAX > 7) begin : g_bad_param
    $error("code_bus_arbiter: MEM_LAT must be 1..4 and STARVE_MAX 0..7");
  end

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  state_t      r_state;
  logic [1:0]  r_cnt;        // remaining ACCESS cycles after this one
  logic        r_owner_d;    // 1: D owns the bus, 0: IF owns it
  logic        r_we;
  logic        r_first;      // first ACCESS cycle: the only write-strobe cycle
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_if_gnt;
  logic        r_d_gnt;
  logic        r_if_valid;
  logic        r_d_valid;
  logic [31:0] r_if_data;
  logic [31:0] r_d_rdata;

  logic        w_force_if;
  logic        w_pick_d;
  logic        w_pick_if;

`ifdef CODE_ARB_STARVE_GUARD_EN
  logic [2:0]  r_starve;

  // Counts D grants issued while IF was waiting; cleared whenever IF is
  // granted or D is granted with IF idle. Saturates at 7.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_starve <= 3'd0;
    end else if (r_state == IDLE) begin
      if (w_pick_if) begin
        r_starve <= 3'd0;
      end else if (w_pick_d) begin
        if (!bus.iIfReq)           r_starve <= 3'd0;
        else if (r_starve != 3'd7) r_starve <= r_starve + 3'd1;
      end
    end
  end
`endif

  // NOTE: always_comb must assign every output on every path (defaults
  // first), otherwise synthesis infers a latch.
  always_comb begin
    w_force_if = 1'b0;
`ifdef CODE_ARB_STARVE_GUARD_EN
    w_force_if = bus.iIfReq && (r_starve == 3'(STARVE_MAX));
`endif
    w_pick_d  = bus.iDReq && !w_force_if;
    w_pick_if = bus.iIfReq && !w_pick_d;
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state    <= IDLE;
      r_cnt      <= 2'd0;
      r_owner_d  <= 1'b0;
      r_we       <= 1'b0;
      r_first    <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_be       <= 4'd0;
      r_if_gnt   <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_if_data  <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      // Grant and valid are single-cycle pulses.
      r_if_gnt   <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_first    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_d || w_pick_if) begin
            r_state   <= ACCESS;
            r_cnt     <= LAT_M1;
            r_first   <= 1'b1;
            r_owner_d <= w_pick_d;
            if (w_pick_d) begin
              r_d_gnt <= 1'b1;
              r_we    <= bus.iDWe;
              r_be    <= bus.iDBe;
              r_addr  <= bus.iDAddr;
              r_wdata <= bus.iDWData;
            end else begin
              // Fetches are full-word reads; write data keeps its old value.
              r_if_gnt <= 1'b1;
              r_we     <= 1'b0;
              r_be     <= 4'b1111;
              r_addr   <= bus.iIfAddr;
            end
          end
        end
        ACCESS: begin
          if (r_cnt == 2'd0) begin
            r_state <= IDLE;
            if (r_owner_d) begin
              r_d_valid <= 1'b1;
              if (!r_we) r_d_rdata <= bus.iMemReadData;
            end else begin
              r_if_valid <= 1'b1;
              r_if_data  <= bus.iMemReadData;
            end
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Enables decode from registered state only, so reset kills them at once.
  assign bus.oMemReadEnable  = (r_state == ACCESS) && !r_we;
  assign bus.oMemWriteEnable = (r_state == ACCESS) && r_we && r_first;
  assign bus.oMemByteEnable  = r_be;
  assign bus.oMemAddress     = r_addr;
  assign bus.oMemWriteData   = r_wdata;
  assign bus.oIfGnt          = r_if_gnt;
  assign bus.oIfValid        = r_if_valid;
  assign bus.oIfData         = r_if_data;
  assign bus.oDGnt           = r_d_gnt;
  assign bus.oDValid         = r_d_valid;
  assign bus.oDRData         = r_d_rdata;
  assign bus.oBusy           = (r_state == ACCESS);

endmodule

// File: tb/tb_code_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_code_bus_arbiter
//   Directed bench for code_bus_arbiter. u_dut1 runs MEM_LAT=1, u_dut3 runs
//   MEM_LAT=3. Inputs are driven and outputs sampled 1 ns after the rising
//   edge; expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_code_bus_arbiter;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int          n_checks;
  int          n_err;

  code_bus_arbiter_if if1 ();
  code_bus_arbiter_if if3 ();

  code_bus_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .iCLK   (clk),
    .iRST_n (rst_n),
    .bus    (if1.slave)
  );

  code_bus_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .iCLK   (clk),
    .iRST_n (rst_n),
    .bus    (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // u_dut3's memory returns a different word every cycle, so the captured
  // value identifies the cycle it was sampled in.
  assign if3.iMemReadData = 32'h1111_0000 + cyc;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grants and valids of one arbiter must be mutually exclusive.
  always @(negedge clk) begin
    if (rst_n) begin
      check("gnt_excl1", 32'(if1.oIfGnt & if1.oDGnt), 32'd0);
      check("val_excl1", 32'(if1.oIfValid & if1.oDValid), 32'd0);
      check("gnt_excl3", 32'(if3.oIfGnt & if3.oDGnt), 32'd0);
    end
  end

  initial begin
    int unsigned n0;
    int d_gnts;
    int if_gnts;
    int d_at_first_if;

    n_checks = 0;
    n_err    = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    if1.iIfReq = 1'b0; if1.iIfAddr = '0; if1.iDReq = 1'b0; if1.iDWe = 1'b0;
    if1.iDBe = '0; if1.iDAddr = '0; if1.iDWData = '0; if1.iMemReadData = '0;
    if3.iIfReq = 1'b0; if3.iIfAddr = '0; if3.iDReq = 1'b0; if3.iDWe = 1'b0;
    if3.iDBe = '0; if3.iDAddr = '0; if3.iDWData = '0;

    // ---- reset state ----
    tick();
    check("rst_busy", 32'(if1.oBusy), 32'd0);
    check("rst_be", 32'(if1.oMemByteEnable), 32'd0);
    check("rst_ren", 32'(if1.oMemReadEnable), 32'd0);
    check("rst_idata", if1.oIfData, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- MEM_LAT=1 IF read ----
    if1.iIfReq = 1'b1; if1.iIfAddr = 32'h0040_0000;
    if1.iMemReadData = 32'h8C08_0004;
    tick();
    check("if_gnt", 32'(if1.oIfGnt), 32'd1);
    check("if_ren_c1", 32'(if1.oMemReadEnable), 32'd1);
    check("if_addr", if1.oMemAddress, 32'h0040_0000);
    check("if_be", 32'(if1.oMemByteEnable), 32'hF);
    check("if_busy", 32'(if1.oBusy), 32'd1);
    check("if_val_early", 32'(if1.oIfValid), 32'd0);
    if1.iIfReq = 1'b0;
    tick();
    check("if_valid", 32'(if1.oIfValid), 32'd1);
    check("if_data", if1.oIfData, 32'h8C08_0004);
    check("if_ren_c2", 32'(if1.oMemReadEnable), 32'd0);
    check("if_gnt_pulse", 32'(if1.oIfGnt), 32'd0);
    tick();
    check("if_valid_pulse", 32'(if1.oIfValid), 32'd0);
    check("if_data_hold", if1.oIfData, 32'h8C08_0004);

    // ---- simultaneous requests: D first, IF right after D's valid ----
    if1.iIfReq = 1'b1; if1.iIfAddr = 32'h0040_0004;
    if1.iDReq = 1'b1; if1.iDWe = 1'b0; if1.iDBe = 4'hF;
    if1.iDAddr = 32'h0040_0100; if1.iMemReadData = 32'h1234_5678;
    tick();
    check("both_dgnt", 32'(if1.oDGnt), 32'd1);
    check("both_ignt0", 32'(if1.oIfGnt), 32'd0);
    if1.iDReq = 1'b0;
    tick();
    check("both_dvalid", 32'(if1.oDValid), 32'd1);
    check("both_drdata", if1.oDRData, 32'h1234_5678);
    check("both_ignt1", 32'(if1.oIfGnt), 32'd0);
    if1.iMemReadData = 32'hCAFE_F00D;
    tick();
    check("both_ignt2", 32'(if1.oIfGnt), 32'd1);
    check("both_iaddr", if1.oMemAddress, 32'h0040_0004);
    if1.iIfReq = 1'b0;
    tick();
    check("both_ivalid", 32'(if1.oIfValid), 32'd1);
    check("both_idata", if1.oIfData, 32'hCAFE_F00D);
    check("both_drd_hold", if1.oDRData, 32'h1234_5678);

    // ---- D write ----
    if1.iDReq = 1'b1; if1.iDWe = 1'b1; if1.iDBe = 4'b0011;
    if1.iDAddr = 32'h0040_0010; if1.iDWData = 32'hDEAD_BEEF;
    if1.iMemReadData = 32'h0BAD_0BAD;
    tick();
    check("wr_gnt", 32'(if1.oDGnt), 32'd1);
    check("wr_wen", 32'(if1.oMemWriteEnable), 32'd1);
    check("wr_ren", 32'(if1.oMemReadEnable), 32'd0);
    check("wr_addr", if1.oMemAddress, 32'h0040_0010);
    check("wr_data", if1.oMemWriteData, 32'hDEAD_BEEF);
    check("wr_be", 32'(if1.oMemByteEnable), 32'b0011);
    if1.iDReq = 1'b0; if1.iDWe = 1'b0;
    tick();
    check("wr_wen_off", 32'(if1.oMemWriteEnable), 32'd0);
    check("wr_dvalid", 32'(if1.oDValid), 32'd1);
    check("wr_rdata_keep", if1.oDRData, 32'h1234_5678);
    tick();
    check("wr_dvalid_pulse", 32'(if1.oDValid), 32'd0);

    // ---- MEM_LAT=3 D read ----
    n0 = cyc;
    if3.iDReq = 1'b1; if3.iDWe = 1'b0; if3.iDBe = 4'hF;
    if3.iDAddr = 32'h0040_0200;
    tick();
    check("l3_gnt", 32'(if3.oDGnt), 32'd1);
    check("l3_ren1", 32'(if3.oMemReadEnable), 32'd1);
    check("l3_addr1", if3.oMemAddress, 32'h0040_0200);
    if3.iDReq = 1'b0;
    tick();
    check("l3_ren2", 32'(if3.oMemReadEnable), 32'd1);
    check("l3_addr2", if3.oMemAddress, 32'h0040_0200);
    check("l3_val2", 32'(if3.oDValid), 32'd0);
    tick();
    check("l3_ren3", 32'(if3.oMemReadEnable), 32'd1);
    check("l3_addr3", if3.oMemAddress, 32'h0040_0200);
    check("l3_val3", 32'(if3.oDValid), 32'd0);
    tick();
    check("l3_val4", 32'(if3.oDValid), 32'd1);
    check("l3_rdata", if3.oDRData, 32'h1111_0000 + n0 + 3);
    check("l3_ren4", 32'(if3.oMemReadEnable), 32'd0);
    check("l3_busy4", 32'(if3.oBusy), 32'd0);

    // ---- reset during write ACCESS ----
    if1.iDReq = 1'b1; if1.iDWe = 1'b1; if1.iDBe = 4'hF;
    if1.iDAddr = 32'h0040_0020; if1.iDWData = 32'h55AA_55AA;
    tick();
    check("rw_wen_pre", 32'(if1.oMemWriteEnable), 32'd1);
    if1.iDReq = 1'b0; if1.iDWe = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_wen_async", 32'(if1.oMemWriteEnable), 32'd0);
    check("rw_busy_async", 32'(if1.oBusy), 32'd0);
    check("rw_gnt_async", 32'(if1.oDGnt), 32'd0);
    check("rw_addr_async", if1.oMemAddress, 32'd0);
    tick();
    rst_n = 1'b1;
    check("rw_no_valid1", 32'(if1.oDValid), 32'd0);
    tick();
    check("rw_no_valid2", 32'(if1.oDValid), 32'd0);
    check("rw_idle", 32'(if1.oBusy), 32'd0);
    if1.iIfReq = 1'b1; if1.iIfAddr = 32'h0040_0040;
    if1.iMemReadData = 32'h0BAD_C0DE;
    tick();
    check("rw_next_gnt", 32'(if1.oIfGnt), 32'd1);
    if1.iIfReq = 1'b0;
    tick();
    check("rw_next_valid", 32'(if1.oIfValid), 32'd1);
    check("rw_next_data", if1.oIfData, 32'h0BAD_C0DE);

    // ---- starvation: D held high while IF waits ----
    if1.iDReq = 1'b1; if1.iDWe = 1'b0; if1.iDAddr = 32'h0040_0300;
    if1.iIfReq = 1'b1; if1.iIfAddr = 32'h0040_0080;
    d_gnts = 0;
    if_gnts = 0;
    d_at_first_if = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if1.oDGnt) d_gnts++;
      if (if1.oIfGnt) begin
        if (if_gnts == 0) d_at_first_if = d_gnts;
        if_gnts++;
      end
    end
    if1.iDReq = 1'b0; if1.iIfReq = 1'b0;
`ifdef CODE_ARB_STARVE_GUARD_EN
    check("stv_d_before_if", 32'(d_at_first_if), 32'd4);
    check("stv_if_gnts", 32'(if_gnts), 32'd2);
    check("stv_d_gnts", 32'(d_gnts), 32'd8);
`else
    check("stv_d_before_if", 32'(d_at_first_if), 32'hFFFF_FFFF);
    check("stv_if_gnts", 32'(if_gnts), 32'd0);
    check("stv_d_gnts", 32'(d_gnts), 32'd10);
`endif
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
